ram_wartend: RTL and testbench
==============================

Name: ram_wartend

Overview:
- Parametrised successor to the single-cycle word RAM.
- Synchronous single-port RAM with:
  - configurable access latency (wait states);
  - per-byte write enables;
  - a busy handshake;
  - one-cycle completion pulses.
- Sits between the processor load/store unit and on-chip memory. It lets the core model slower memories without changing the request interface.

Parameters:
- WORDSIZE, 32, data word width in bits; must be a multiple of 8.
- WORDS, 32, number of words; need not be a power of two.
- WARTEZYKLEN, 0, extra wait cycles before each access is performed (0..255).

Ports:
- Clock  input  1  system clock, all logic on rising edge
- Reset  input  1  synchronous, active-high reset
- LesenAn  input  1  read request
- SchreibenAn  input  1  write request
- ByteAn  input  WORDSIZE/8  byte write enables; bit i covers DatenRein[8i+7:8i]
- DatenRein  input  WORDSIZE  write data
- Adresse  input  $clog2(WORDS)  word address
- DatenRaus  output  WORDSIZE  read data, registered
- DatenBereit  output  1  one-cycle pulse: read completed, DatenRaus valid
- DatenGeschrieben  output  1  one-cycle pulse: write completed
- Beschaeftigt  output  1  high while an accepted access is pending

Behaviour:
- Reset: Reset sampled high at a rising edge produces the following state:
  - outputs: DatenRaus=0, DatenBereit=0, DatenGeschrieben=0, Beschaeftigt=0;
  - FSM returns to BEREIT;
  - any pending access is discarded and memory is not modified by it;
  - memory contents are not cleared (zero-initialised at time 0 only).
- FSM states:
  - BEREIT:
    - Sample LesenAn/SchreibenAn at each edge.
    - If either is high, latch Adresse, DatenRein, ByteAn and the request type.
    - WARTEZYKLEN=0: perform the access at the same edge; stay in BEREIT.
    - WARTEZYKLEN>0: load the wait counter with WARTEZYKLEN-1, go to WARTEN, set Beschaeftigt=1.
  - WARTEN:
    - Decrement the counter each edge.
    - At the edge where the counter is 0, perform the latched access, clear Beschaeftigt and return to BEREIT.
- Latency:
  - A request sampled at edge k completes at edge k+WARTEZYKLEN.
  - The pulse is high for exactly the one cycle following that edge.
  - Beschaeftigt is high for exactly WARTEZYKLEN cycles.
- Requests while Beschaeftigt=1 are ignored: not queued, no pulse. The first new request can be sampled at the edge ending the pulse cycle.
- Read:
  - DatenRaus <= Daten[Adresse]; DatenBereit pulses.
  - DatenRaus holds its value until the next completed read or reset.
- Write:
  - Only bytes with ByteAn[i]=1 are updated; the other bytes are preserved.
  - ByteAn=0 writes nothing but DatenGeschrieben still pulses.
- Simultaneous LesenAn and SchreibenAn:
  - Both operations are performed on the same address at the same completion edge.
  - DatenRaus returns the pre-write word.
  - Both pulses are high in the same cycle.
- Back-to-back with WARTEZYKLEN=0: one access per cycle; a pulse stays high continuously while requests continue.
- A read following a write to the same address returns the written data.
- Reset asserted in WARTEN: the access is aborted, there is no pulse, and memory is unchanged.
- Address range and out-of-range accesses: Adresse is the full $clog2(WORDS)-bit value; handling of Adresse >= WORDS is defined under Optional Feature.

Optional Feature:
- Macro: RAM_ADRESSPRUEFUNG_EN.
- Defined:
  - Adds output port AdressFehler (output, 1 bit, reset 0).
  - An access with Adresse >= WORDS completes with normal latency and handshake.
  - Read: DatenRaus=0. Write: memory is unchanged.
  - AdressFehler pulses in the same cycle as DatenBereit/DatenGeschrieben.
- Not defined:
  - No AdressFehler port.
  - Out-of-range reads return 0 and out-of-range writes are silently discarded.
  - Handshake is identical to the defined case.

Test Plan:
1. WARTEZYKLEN=0: write 0xDEADBEEF to address 3 with ByteAn=4'b1111, then read address 3 → DatenGeschrieben one cycle after the write request; DatenBereit with DatenRaus=0xDEADBEEF one cycle after the read request; Beschaeftigt stays 0.
2. Partial writes: address 5 holds 0x11223344; write 0xAABBCCDD with ByteAn=4'b0101 → read gives 0x11BB33DD. A write with ByteAn=0 leaves 0x11BB33DD and still pulses DatenGeschrieben.
3. WARTEZYKLEN=3: read request at edge 0 → Beschaeftigt high for 3 cycles, DatenBereit pulse after edge 3. A second request held during edges 1-2 is ignored, with no extra pulse.
4. Simultaneous read+write to address 7 (old 0x00000005, new 0x00000009) → DatenRaus=0x00000005 and both pulses in the same cycle; a following read returns 0x00000009.
5. WARTEZYKLEN=4: write to address 2, Reset pulsed at edge 2 → no DatenGeschrieben, all outputs 0, address 2 still holds its old value. A new request after reset completes normally.
6. WORDS=20 with RAM_ADRESSPRUEFUNG_EN: write 0x1234 to address 25, then read address 25 → both accesses give AdressFehler pulses, read returns 0; address 25 mod 20 = 5 is unchanged. Without the macro, the same stimulus gives the same data and pulses, and no AdressFehler port exists.

Source files
------------

// File: rtl/ram_wartend_if.sv
// ram_wartend_if: request/response bundle between a load/store unit and ram_wartend.
// Optional AdressFehler signal present only when RAM_ADRESSPRUEFUNG_EN is defined.
interface ram_wartend_if #(
  parameter int unsigned WORDSIZE = 32,
  parameter int unsigned WORDS    = 32
);
  localparam int unsigned AW = $clog2(WORDS);

  logic                  LesenAn;
  logic                  SchreibenAn;
  logic [WORDSIZE/8-1:0] ByteAn;
  logic [WORDSIZE-1:0]   DatenRein;
  logic [AW-1:0]         Adresse;
  logic [WORDSIZE-1:0]   DatenRaus;
  logic                  DatenBereit;
  logic                  DatenGeschrieben;
  logic                  Beschaeftigt;
`ifdef RAM_ADRESSPRUEFUNG_EN
  logic                  AdressFehler;
`endif

  modport master (
    output LesenAn, SchreibenAn, ByteAn, DatenRein, Adresse,
    input  DatenRaus, DatenBereit, DatenGeschrieben, Beschaeftigt
`ifdef RAM_ADRESSPRUEFUNG_EN
    , input AdressFehler
`endif
  );

  modport slave (
    input  LesenAn, SchreibenAn, ByteAn, DatenRein, Adresse,
    output DatenRaus, DatenBereit, DatenGeschrieben, Beschaeftigt
`ifdef RAM_ADRESSPRUEFUNG_EN
    , output AdressFehler
`endif
  );
endinterface

// File: rtl/ram_wartend.sv
// ram_wartend: single-port word RAM with configurable wait states, byte write
// enables, busy flag and one-cycle completion pulses.
// Optional macro RAM_ADRESSPRUEFUNG_EN adds the AdressFehler pulse for Adresse >= WORDS.
module ram_wartend #(
  parameter int unsigned WORDSIZE    = 32,
  parameter int unsigned WORDS       = 32,
  parameter int unsigned WARTEZYKLEN = 0
) (
  input  logic          Clock,
  input  logic          Reset,
  ram_wartend_if.slave  bus
);
  localparam int unsigned AW = $clog2(WORDS);
  localparam int unsigned NB = WORDSIZE / 8;

  typedef enum logic {BEREIT, WARTEN} zustand_t;

  zustand_t            zustand, zustandNext;
  logic [7:0]          zaehler, zaehlerNext;

  logic                latLesen, latSchreiben;
  logic [NB-1:0]       latByteAn;
  logic [WORDSIZE-1:0] latDaten;
  logic [AW-1:0]       latAdresse;

  logic                anfrage;
  logic                uebernehmen;
  logic                zugriff;
  logic                accLesen, accSchreiben;
  logic [NB-1:0]       accByteAn;
  logic [WORDSIZE-1:0] accDaten;
  logic [AW-1:0]       accAdresse;
  logic                imBereich;

  logic [WORDSIZE-1:0] daten [WORDS] = '{default: '0};

  assign anfrage      = bus.LesenAn | bus.SchreibenAn;
  assign imBereich    = 32'(accAdresse) < WORDS;
  assign bus.Beschaeftigt = (zustand == WARTEN);

  // Next-state logic; selects either the live request (no wait states) or the
  // latched one (end of WARTEN) as the access performed at this edge.
  always_comb begin
    zustandNext  = zustand;
    zaehlerNext  = zaehler;
    uebernehmen  = 1'b0;
    zugriff      = 1'b0;
    accLesen     = bus.LesenAn;
    accSchreiben = bus.SchreibenAn;
    accByteAn    = bus.ByteAn;
    accDaten     = bus.DatenRein;
    accAdresse   = bus.Adresse;
    case (zustand)
      BEREIT: begin
        if (anfrage) begin
          if (WARTEZYKLEN == 0) begin
            zugriff = 1'b1;
          end else begin
            uebernehmen = 1'b1;
            zaehlerNext = 8'(WARTEZYKLEN - 1);
            zustandNext = WARTEN;
          end
        end
      end
      WARTEN: begin
        accLesen     = latLesen;
        accSchreiben = latSchreiben;
        accByteAn    = latByteAn;
        accDaten     = latDaten;
        accAdresse   = latAdresse;
        if (zaehler == '0) begin
          zugriff     = 1'b1;
          zustandNext = BEREIT;
        end else begin
          zaehlerNext = zaehler - 8'd1;
        end
      end
      default: zustandNext = BEREIT;
    endcase
  end

  // State register and wait counter.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      zustand <= BEREIT;
      zaehler <= '0;
    end else begin
      zustand <= zustandNext;
      zaehler <= zaehlerNext;
    end
  end

  // Capture the accepted request for a delayed access.
  always_ff @(posedge Clock) begin
    if (uebernehmen) begin
      latLesen     <= bus.LesenAn;
      latSchreiben <= bus.SchreibenAn;
      latByteAn    <= bus.ByteAn;
      latDaten     <= bus.DatenRein;
      latAdresse   <= bus.Adresse;
    end
  end

  // Byte-masked memory write; a reset edge aborts any access.
  always_ff @(posedge Clock) begin
    if (!Reset && zugriff && accSchreiben && imBereich) begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (accByteAn[i]) daten[accAdresse][8*i +: 8] <= accDaten[8*i +: 8];
      end
    end
  end

  // Registered read data (pre-write word) and completion pulses.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      bus.DatenRaus        <= '0;
      bus.DatenBereit      <= 1'b0;
      bus.DatenGeschrieben <= 1'b0;
    end else begin
      bus.DatenBereit      <= zugriff & accLesen;
      bus.DatenGeschrieben <= zugriff & accSchreiben;
      if (zugriff && accLesen) bus.DatenRaus <= imBereich ? daten[accAdresse] : '0;
    end
  end

`ifdef RAM_ADRESSPRUEFUNG_EN
  // Address error pulse aligned with the completion pulses.
  always_ff @(posedge Clock) begin
    if (Reset) bus.AdressFehler <= 1'b0;
    else       bus.AdressFehler <= zugriff & ~imBereich;
  end
`endif
endmodule

// File: tb/tb_ram_wartend.sv
// tb_ram_wartend: three ram_wartend instances (0, 3 and 4 wait states) checked
// against a transaction-level model plus directed literal expectations.
module tb_ram_wartend;
  logic Clock = 1'b0;
  always #5 Clock = ~Clock;

  int checks = 0;
  int errors = 0;

  // Per-instance stimulus and observed outputs (0: W=0/WORDS=20, 1: W=3, 2: W=4).
  logic        rstV      [3];
  logic        lesen     [3];
  logic        schreiben [3];
  logic [3:0]  be        [3];
  logic [31:0] din       [3];
  logic [4:0]  adr       [3];
  logic [31:0] dout      [3];
  logic        bereit    [3];
  logic        geschr    [3];
  logic        besch     [3];
  logic        fehler    [3];

  ram_wartend_if #(.WORDSIZE(32), .WORDS(20)) bus0 ();
  ram_wartend_if #(.WORDSIZE(32), .WORDS(32)) bus1 ();
  ram_wartend_if #(.WORDSIZE(32), .WORDS(32)) bus2 ();

  ram_wartend #(.WORDSIZE(32), .WORDS(20), .WARTEZYKLEN(0)) dut0 (.Clock(Clock), .Reset(rstV[0]), .bus(bus0));
  ram_wartend #(.WORDSIZE(32), .WORDS(32), .WARTEZYKLEN(3)) dut1 (.Clock(Clock), .Reset(rstV[1]), .bus(bus1));
  ram_wartend #(.WORDSIZE(32), .WORDS(32), .WARTEZYKLEN(4)) dut2 (.Clock(Clock), .Reset(rstV[2]), .bus(bus2));

  assign bus0.LesenAn = lesen[0];  assign bus0.SchreibenAn = schreiben[0];
  assign bus0.ByteAn  = be[0];     assign bus0.DatenRein   = din[0];  assign bus0.Adresse = adr[0];
  assign bus1.LesenAn = lesen[1];  assign bus1.SchreibenAn = schreiben[1];
  assign bus1.ByteAn  = be[1];     assign bus1.DatenRein   = din[1];  assign bus1.Adresse = adr[1];
  assign bus2.LesenAn = lesen[2];  assign bus2.SchreibenAn = schreiben[2];
  assign bus2.ByteAn  = be[2];     assign bus2.DatenRein   = din[2];  assign bus2.Adresse = adr[2];

  assign dout[0] = bus0.DatenRaus; assign bereit[0] = bus0.DatenBereit;
  assign geschr[0] = bus0.DatenGeschrieben; assign besch[0] = bus0.Beschaeftigt;
  assign dout[1] = bus1.DatenRaus; assign bereit[1] = bus1.DatenBereit;
  assign geschr[1] = bus1.DatenGeschrieben; assign besch[1] = bus1.Beschaeftigt;
  assign dout[2] = bus2.DatenRaus; assign bereit[2] = bus2.DatenBereit;
  assign geschr[2] = bus2.DatenGeschrieben; assign besch[2] = bus2.Beschaeftigt;
`ifdef RAM_ADRESSPRUEFUNG_EN
  assign fehler[0] = bus0.AdressFehler;
  assign fehler[1] = bus1.AdressFehler;
  assign fehler[2] = bus2.AdressFehler;
`else
  assign fehler[0] = 1'b0;
  assign fehler[1] = 1'b0;
  assign fehler[2] = 1'b0;
`endif

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  int unsigned wz    [3] = '{0, 3, 4};
  int unsigned words [3] = '{20, 32, 32};
  logic [31:0] mm [3][32] = '{default: '0};
  int          cyc = 0;
  logic        pend [3] = '{default: 1'b0};
  int          doneAt [3];
  logic        pR [3], pW [3];
  logic [4:0]  pA [3];
  logic [31:0] pD [3];
  logic [3:0]  pB [3];
  logic [31:0] eRaus [3] = '{default: '0};
  logic        eBer [3], eGes [3], eBes [3], eFeh [3];

  task automatic doOp(input int d, input logic r, input logic w, input logic [4:0] a,
                      input logic [31:0] dat, input logic [3:0] b);
    if (a < words[d]) begin
      if (r) eRaus[d] = mm[d][a];
      if (w) for (int i = 0; i < 4; i++) if (b[i]) mm[d][a][8*i +: 8] = dat[8*i +: 8];
    end else if (r) begin
      eRaus[d] = '0;
    end
    eBer[d] = r;
    eGes[d] = w;
    eFeh[d] = (a >= words[d]);
  endtask

  // A request accepted at cycle k completes at k+W; nothing is accepted while one is pending.
  always @(posedge Clock) begin
    cyc++;
    for (int d = 0; d < 3; d++) begin
      if (rstV[d]) begin
        eRaus[d] = '0; eBer[d] = 0; eGes[d] = 0; eBes[d] = 0; eFeh[d] = 0; pend[d] = 0;
      end else begin
        eBer[d] = 0; eGes[d] = 0; eFeh[d] = 0;
        if (pend[d]) begin
          if (cyc == doneAt[d]) begin
            doOp(d, pR[d], pW[d], pA[d], pD[d], pB[d]);
            pend[d] = 0;
          end
        end else if (lesen[d] || schreiben[d]) begin
          if (wz[d] == 0) doOp(d, lesen[d], schreiben[d], adr[d], din[d], be[d]);
          else begin
            pend[d] = 1; doneAt[d] = cyc + int'(wz[d]);
            pR[d] = lesen[d]; pW[d] = schreiben[d]; pA[d] = adr[d]; pD[d] = din[d]; pB[d] = be[d];
          end
        end
        eBes[d] = pend[d];
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge Clock) begin
    if (cyc > 0) begin
      for (int d = 0; d < 3; d++) begin
        check($sformatf("dut%0d DatenRaus", d), dout[d], eRaus[d]);
        check($sformatf("dut%0d DatenBereit", d), 32'(bereit[d]), 32'(eBer[d]));
        check($sformatf("dut%0d DatenGeschrieben", d), 32'(geschr[d]), 32'(eGes[d]));
        check($sformatf("dut%0d Beschaeftigt", d), 32'(besch[d]), 32'(eBes[d]));
`ifdef RAM_ADRESSPRUEFUNG_EN
        check($sformatf("dut%0d AdressFehler", d), 32'(fehler[d]), 32'(eFeh[d]));
`endif
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic issue(input int d, input logic r, input logic w, input logic [4:0] a,
                       input logic [31:0] dat, input logic [3:0] b);
    lesen[d] = r; schreiben[d] = w; adr[d] = a; din[d] = dat; be[d] = b;
  endtask

  task automatic idle(input int d);
    lesen[d] = 0; schreiben[d] = 0; adr[d] = '0; din[d] = '0; be[d] = '0;
  endtask

  // Zero-wait access: request sampled at the next edge, pulse visible right after.
  task automatic acc0(input logic r, input logic w, input logic [4:0] a,
                      input logic [31:0] dat, input logic [3:0] b);
    issue(0, r, w, a, dat, b);
    step();
    idle(0);
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      idle(d);
      rstV[d] = 1'b1;
    end
    step();
    step();
    for (int d = 0; d < 3; d++) rstV[d] = 1'b0;
    check("reset DatenRaus", dout[1], 32'h0);
    check("reset Beschaeftigt", 32'(besch[2]), 32'h0);
    check("reset DatenBereit", 32'(bereit[0]), 32'h0);

    // Zero wait states: full write then read.
    acc0(0, 1, 5'd3, 32'hDEADBEEF, 4'hF);
    check("t1 write pulse", 32'(geschr[0]), 32'h1);
    check("t1 not busy", 32'(besch[0]), 32'h0);
    acc0(1, 0, 5'd3, 32'h0, 4'h0);
    check("t1 read pulse", 32'(bereit[0]), 32'h1);
    check("t1 read data", dout[0], 32'hDEADBEEF);

    // Partial writes and an empty byte mask.
    acc0(0, 1, 5'd5, 32'h11223344, 4'hF);
    acc0(0, 1, 5'd5, 32'hAABBCCDD, 4'b0101);
    acc0(1, 0, 5'd5, 32'h0, 4'h0);
    check("t2 partial", dout[0], 32'h11BB33DD);
    acc0(0, 1, 5'd5, 32'hFFFFFFFF, 4'h0);
    check("t2 empty mask pulse", 32'(geschr[0]), 32'h1);
    acc0(1, 0, 5'd5, 32'h0, 4'h0);
    check("t2 empty mask data", dout[0], 32'h11BB33DD);

    // Back-to-back reads: pulse stays high.
    issue(0, 1, 0, 5'd3, 32'h0, 4'h0);
    step();
    check("b2b first", dout[0], 32'hDEADBEEF);
    issue(0, 1, 0, 5'd5, 32'h0, 4'h0);
    step();
    idle(0);
    check("b2b second", dout[0], 32'h11BB33DD);
    check("b2b pulse held", 32'(bereit[0]), 32'h1);

    // Simultaneous read and write returns the old word.
    acc0(0, 1, 5'd7, 32'h00000005, 4'hF);
    acc0(1, 1, 5'd7, 32'h00000009, 4'hF);
    check("t4 old data", dout[0], 32'h00000005);
    check("t4 both pulses", 32'({bereit[0], geschr[0]}), 32'h3);
    acc0(1, 0, 5'd7, 32'h0, 4'h0);
    check("t4 new data", dout[0], 32'h00000009);

    // Out-of-range address on WORDS=20.
    acc0(0, 1, 5'd25, 32'h00001234, 4'hF);
    check("t6 write pulse", 32'(geschr[0]), 32'h1);
`ifdef RAM_ADRESSPRUEFUNG_EN
    check("t6 write error", 32'(fehler[0]), 32'h1);
`endif
    acc0(1, 0, 5'd25, 32'h0, 4'h0);
    check("t6 read zero", dout[0], 32'h0);
    check("t6 read pulse", 32'(bereit[0]), 32'h1);
`ifdef RAM_ADRESSPRUEFUNG_EN
    check("t6 read error", 32'(fehler[0]), 32'h1);
`endif
    acc0(1, 0, 5'd5, 32'h0, 4'h0);
    check("t6 alias untouched", dout[0], 32'h11BB33DD);

    // Three wait states.
    issue(1, 0, 1, 5'd1, 32'hCAFEF00D, 4'hF);
    step();
    idle(1);
    check("t3 write busy", 32'(besch[1]), 32'h1);
    step();
    step();
    check("t3 write not yet", 32'(geschr[1]), 32'h0);
    step();
    check("t3 write done", 32'(geschr[1]), 32'h1);
    check("t3 write idle", 32'(besch[1]), 32'h0);
    issue(1, 1, 0, 5'd1, 32'h0, 4'h0);
    step();
    issue(1, 1, 0, 5'd2, 32'h0, 4'h0);
    step();
    step();
    idle(1);
    check("t3 read not yet", 32'(bereit[1]), 32'h0);
    check("t3 read busy", 32'(besch[1]), 32'h1);
    step();
    check("t3 read pulse", 32'(bereit[1]), 32'h1);
    check("t3 read data", dout[1], 32'hCAFEF00D);
    step();
    check("t3 no extra pulse", 32'(bereit[1]), 32'h0);

    // Four wait states with reset during WARTEN.
    issue(2, 0, 1, 5'd2, 32'h55AA55AA, 4'hF);
    step();
    idle(2);
    repeat (4) step();
    check("t5 write done", 32'(geschr[2]), 32'h1);
    issue(2, 1, 0, 5'd2, 32'h0, 4'h0);
    step();
    idle(2);
    repeat (4) step();
    check("t5 read before", dout[2], 32'h55AA55AA);
    issue(2, 0, 1, 5'd2, 32'h0BAD0BAD, 4'hF);
    step();
    idle(2);
    step();
    rstV[2] = 1'b1;
    step();
    rstV[2] = 1'b0;
    check("t5 reset data", dout[2], 32'h0);
    check("t5 reset busy", 32'(besch[2]), 32'h0);
    repeat (4) step();
    check("t5 no write pulse", 32'(geschr[2]), 32'h0);
    issue(2, 1, 0, 5'd2, 32'h0, 4'h0);
    step();
    idle(2);
    repeat (3) step();
    check("t5 new req busy", 32'(besch[2]), 32'h1);
    step();
    check("t5 memory kept", dout[2], 32'h55AA55AA);
    check("t5 new req pulse", 32'(bereit[2]), 32'h1);
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
